// File: rtl/spi_flash_rd_seq.sv
// spi_flash_rd_seq: APB master sequencer driving a CORESPI slave (Motorola,
// master, 8-bit frames) to run SPI flash read commands. It sends the opcode
// and address header, clocks dummy bytes for the data phase, and streams
// received bytes on a valid/ready port.
// Optional feature: define SPI_SEQ_ADDR4_EN for a 32-bit cmd_addr and a
// 4-byte address header (addr[31:24] sent first). Default is 3-byte address.
module spi_flash_rd_seq #(
  parameter int          LEN_W       = 16,
  parameter int          SLAVE_IDX   = 0,
  parameter int          POLL_MAX    = 1023,
  parameter logic [6:0]  REG_CONTROL = 7'h00,
  parameter logic [6:0]  REG_RXDATA  = 7'h08,
  parameter logic [6:0]  REG_TXDATA  = 7'h0C,
  parameter logic [6:0]  REG_STATUS  = 7'h20,
  parameter logic [6:0]  REG_SSEL    = 7'h24,
  parameter logic [31:0] CTRL_INIT   = 32'h0000_0003
) (
  input  logic             PCLK,
  input  logic             PRESETN,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_opcode,
`ifdef SPI_SEQ_ADDR4_EN
  input  logic [31:0]      cmd_addr,
`else
  input  logic [23:0]      cmd_addr,
`endif
  input  logic [LEN_W-1:0] cmd_len,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [6:0]       M_PADDR,
  output logic             M_PSEL,
  output logic             M_PENABLE,
  output logic             M_PWRITE,
  output logic [31:0]      M_PWDATA,
  input  logic [31:0]      M_PRDATA,
  input  logic             M_PREADY,
  input  logic             M_PSLVERR
);

`ifdef SPI_SEQ_ADDR4_EN
  localparam int ADDR_BYTES = 4;
`else
  localparam int ADDR_BYTES = 3;
`endif
  localparam int HDR_BYTES = ADDR_BYTES + 1;
  localparam int HDR_W     = 8 * HDR_BYTES;
  localparam int POLL_W    = $clog2(POLL_MAX + 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);
  localparam logic [31:0] SSEL_ON_VAL = 32'(1) << SLAVE_IDX;

  typedef enum logic [3:0] {
    ST_INIT_SSEL,
    ST_INIT_CTL,
    ST_IDLE,
    ST_SSEL_ON,
    ST_TX_WR,
    ST_POLL,
    ST_RX_RD,
    ST_OUT,
    ST_SSEL_OFF,
    ST_ABORT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_GAP,
    PH_SETUP,
    PH_ACCESS
  } phase_t;

  state_t              state_q, state_d;
  phase_t              phase_q, phase_d;
  logic [HDR_W-1:0]    hdr_q, hdr_d;
  logic [2:0]          hdr_left_q, hdr_left_d;
  logic                cur_hdr_q, cur_hdr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic                err_q, err_d;

  logic                acc_req;
  logic [6:0]          acc_addr;
  logic                acc_write;
  logic [31:0]         acc_wdata;
  logic [7:0]          tx_byte;
  logic                psel;
  logic                penable;
  logic                acc_done;
  logic                acc_err;
  logic                prdata_unused;

  assign prdata_unused = ^M_PRDATA[31:8];

  // Decode which register access (if any) the current state performs.
  always_comb begin
    acc_req   = 1'b1;
    acc_addr  = REG_SSEL;
    acc_write = 1'b1;
    acc_wdata = 32'h0;
    tx_byte   = (hdr_left_q != 3'd0) ? hdr_q[HDR_W-1 -: 8] : 8'h00;
    case (state_q)
      ST_INIT_SSEL, ST_SSEL_OFF, ST_ABORT: begin
        acc_wdata = 32'h0;
      end
      ST_INIT_CTL: begin
        acc_addr  = REG_CONTROL;
        acc_wdata = CTRL_INIT;
      end
      ST_SSEL_ON: begin
        acc_wdata = SSEL_ON_VAL;
      end
      ST_TX_WR: begin
        acc_addr  = REG_TXDATA;
        acc_wdata = {24'h0, tx_byte};
      end
      ST_POLL: begin
        acc_addr  = REG_STATUS;
        acc_write = 1'b0;
      end
      ST_RX_RD: begin
        acc_addr  = REG_RXDATA;
        acc_write = 1'b0;
      end
      default: begin
        acc_req   = 1'b0;
        acc_write = 1'b0;
      end
    endcase
  end

  assign psel      = acc_req && (phase_q != PH_GAP);
  assign penable   = acc_req && (phase_q == PH_ACCESS);
  assign acc_done  = penable && M_PREADY;
  assign acc_err   = acc_done && M_PSLVERR;

  assign M_PSEL    = psel;
  assign M_PENABLE = penable;
  assign M_PWRITE  = psel && acc_write;
  assign M_PADDR   = psel ? acc_addr : 7'h0;
  assign M_PWDATA  = psel ? acc_wdata : 32'h0;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = !(state_q inside {ST_INIT_SSEL, ST_INIT_CTL, ST_IDLE});
  assign rd_valid  = (state_q == ST_OUT);
  assign rd_data   = rd_data_q;
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_DONE) && err_q;

  // Next-state logic: APB phase stepping plus the command sequencing.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    hdr_d      = hdr_q;
    hdr_left_d = hdr_left_q;
    cur_hdr_d  = cur_hdr_q;
    len_d      = len_q;
    poll_cnt_d = poll_cnt_q;
    rd_data_d  = rd_data_q;
    err_d      = err_q;

    if (acc_req) begin
      case (phase_q)
        PH_GAP:   phase_d = PH_SETUP;
        PH_SETUP: phase_d = PH_ACCESS;
        default:  if (M_PREADY) phase_d = PH_GAP;
      endcase
    end

    case (state_q)
      ST_INIT_SSEL: if (acc_done) state_d = ST_INIT_CTL;
      ST_INIT_CTL:  if (acc_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (cmd_valid) begin
          hdr_d      = {cmd_opcode, cmd_addr};
          hdr_left_d = 3'(HDR_BYTES);
          len_d      = cmd_len;
          err_d      = 1'b0;
          state_d    = ST_SSEL_ON;
        end
      end
      ST_SSEL_ON: if (acc_done) state_d = ST_TX_WR;
      ST_TX_WR: begin
        if (acc_done) begin
          cur_hdr_d = (hdr_left_q != 3'd0);
          if (hdr_left_q != 3'd0) begin
            hdr_d      = hdr_q << 8;
            hdr_left_d = hdr_left_q - 3'd1;
          end
          poll_cnt_d = '0;
          state_d    = ST_POLL;
        end
      end
      ST_POLL: begin
        if (acc_done) begin
          if (!M_PRDATA[2]) begin
            state_d = ST_RX_RD;
          end else if (poll_cnt_q == POLL_LAST) begin
            state_d = ST_ABORT;
            err_d   = 1'b1;
          end else begin
            poll_cnt_d = poll_cnt_q + POLL_W'(1);
          end
        end
      end
      ST_RX_RD: begin
        if (acc_done) begin
          if (cur_hdr_q) begin
            if ((hdr_left_q != 3'd0) || (len_q != '0)) state_d = ST_TX_WR;
            else                                         state_d = ST_SSEL_OFF;
          end else begin
            rd_data_d = M_PRDATA[7:0];
            state_d   = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (rd_ready) begin
          if (len_q != '0) len_d = len_q - LEN_W'(1);
          if (len_q > LEN_W'(1)) state_d = ST_TX_WR;
          else                   state_d = ST_SSEL_OFF;
        end
      end
      ST_SSEL_OFF: if (acc_done) state_d = ST_DONE;
      ST_ABORT:    if (acc_done) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_INIT_SSEL;
    endcase

    // A slave error on any access except the abort's own SSEL write aborts.
    if (acc_err && (state_q != ST_ABORT)) begin
      state_d = ST_ABORT;
      err_d   = 1'b1;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      state_q    <= ST_INIT_SSEL;
      phase_q    <= PH_GAP;
      hdr_q      <= '0;
      hdr_left_q <= 3'd0;
      cur_hdr_q  <= 1'b0;
      len_q      <= '0;
      poll_cnt_q <= '0;
      rd_data_q  <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      hdr_q      <= hdr_d;
      hdr_left_q <= hdr_left_d;
      cur_hdr_q  <= cur_hdr_d;
      len_q      <= len_d;
      poll_cnt_q <= poll_cnt_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: doc/spi_flash_rd_seq.md
Name: spi_flash_rd_seq

Overview:
- APB master sequencer that drives the CORESPI APB slave (Motorola mode, master, 8-bit frames) to perform SPI flash read commands.
- Accepts one command at a time: opcode, address and byte count.
- Issues the command header, clocks dummy bytes and streams the received data bytes out on a valid/ready interface.
- Sits between the fabric command logic and the CORESPI instance on the same PCLK domain.

Parameters:
- LEN_W, 16, width of cmd_len (max bytes per command = 2^LEN_W-1).
- SLAVE_IDX, 0, SPISS line asserted during a command (0..7).
- POLL_MAX, 1023, max STATUS polls per byte before timeout.
- REG_CONTROL, 7'h00, CORESPI CONTROL offset.
- REG_RXDATA, 7'h08, RXDATA offset.
- REG_TXDATA, 7'h0C, TXDATA offset.
- REG_STATUS, 7'h20, STATUS offset (bit2 = rx FIFO empty).
- REG_SSEL, 7'h24, SSEL offset.
- CTRL_INIT, 32'h0000_0003, CONTROL value written at init (enable | master).

Ports:
- PCLK  in  1  clock
- PRESETN  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when valid&ready
- cmd_opcode  in  8  SPI opcode (e.g. 8'h03)
- cmd_addr  in  24  flash byte address, sent MSB first (32 with SPI_SEQ_ADDR4_EN)
- cmd_len  in  LEN_W  data bytes to read
- rd_valid  out  1  read byte valid
- rd_ready  in  1  consumer accepts byte
- rd_data  out  8  read byte
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command end
- err  out  1  one-cycle pulse with done on timeout or PSLVERR
- M_PADDR  out  7  APB address to CORESPI
- M_PSEL  out  1  APB select
- M_PENABLE  out  1  APB enable
- M_PWRITE  out  1  APB write
- M_PWDATA  out  32  APB write data
- M_PRDATA  in  32  APB read data
- M_PREADY  in  1  APB ready
- M_PSLVERR  in  1  APB slave error

Behaviour:
- Clock and reset: one clock, PCLK. Reset is synchronous, active-low on PRESETN.
- Reset values: all outputs 0, except M_PADDR and M_PWDATA, which are 0 and don't-care. The FSM goes to INIT_SSEL.
- APB access: every register access is SETUP (PSEL=1, PENABLE=0), then ACCESS (PSEL=1, PENABLE=1) held until PREADY.
  - PADDR, PWRITE and PWDATA stay stable across both phases.
  - PSEL drops for at least 1 cycle between accesses.
  - PSLVERR sampled with PREADY=1 -> go to ABORT.
- INIT_SSEL: write SSEL=0. Then INIT_CTL: write CONTROL=CTRL_INIT. Then IDLE.
  - This sequence also recovers a reset that lands mid-command.
- IDLE: cmd_ready=1, busy=0.
  - On cmd_valid, latch opcode, address and length into a header shift register and a remaining-byte counter.
  - Go to SSEL_ON with busy=1. cmd_ready is 0 outside IDLE.
- SSEL_ON: write SSEL = 1<<SLAVE_IDX.
- TX_WR: write TXDATA = {24'h0, byte}.
  - byte is the next header byte (opcode, then addr[23:16], [15:8], [7:0]), or 8'h00 in the data phase.
- POLL: read STATUS repeatedly until bit2==0.
  - Count completed reads; at POLL_MAX reads with bit2 still 1 -> ABORT.
- RX_RD: read RXDATA.
  - Header phase: discard the byte, then TX_WR the next header byte, or the first data byte when the header is exhausted.
  - Data phase: load rd_data = PRDATA[7:0] and go to OUT.
- Header with cmd_len=0: after the last header byte, go to SSEL_OFF. No rd_valid is ever asserted.
- OUT: rd_valid=1 with rd_data stable until rd_ready.
  - The byte transfers on the cycle rd_valid&rd_ready; rd_valid drops the next cycle.
  - Decrement the counter. Go to TX_WR if bytes remain, else SSEL_OFF.
  - No new TXDATA write is issued while a byte is pending, so backpressure throttles SPI.
- SSEL_OFF: write SSEL=0. Then done=1 for 1 cycle, then IDLE.
- ABORT: finish any in-flight APB access, write SSEL=0, then pulse done=1 and err=1 together, then IDLE.
  - A PSLVERR during this SSEL write is ignored.
- Counter: LEN_W bits; no wrap, because it is only decremented when nonzero.
- Flash address wrap is the flash device's concern and is not checked.

Optional Feature:
- Macro: SPI_SEQ_ADDR4_EN.
- When defined: cmd_addr is 32 bits and the header is opcode plus 4 address bytes (addr[31:24] first), for 4-byte-address flash.
- When undefined: cmd_addr is 24 bits with a 3-byte address.
- All other behaviour is identical.

Test Plan:
- Reset then idle: APB write sequence SSEL=0, then CONTROL=32'h3. cmd_ready=1 afterwards; rd_valid, done and err stay 0.
- cmd opcode=8'h03, addr=24'h012345, len=4; slave model returns A0..A3 in the data phase.
  - TXDATA writes are 03,01,23,45,00,00,00,00.
  - rd_data is A0,A1,A2,A3 in order.
  - SSEL writes are 01, then 00.
  - done pulses once, err=0.
- len=0: exactly 4 TXDATA writes, zero rd_valid, SSEL 01 then 00, done pulse.
- rd_ready held low 50 cycles on byte 2: rd_valid and rd_data stay stable, and no TXDATA write occurs until acceptance.
- STATUS bit2 stuck 1 with POLL_MAX=8: after 8 STATUS reads, SSEL=0 is written and done and err pulse together. The next command works normally.
- PRESETN low for 1 cycle mid data phase: all outputs 0 on the next cycle, then the INIT sequence (SSEL=0, CONTROL=3) replays.
  - With SPI_SEQ_ADDR4_EN, addr=32'h89ABCDEF sends header bytes 03,89,AB,CD,EF.
